// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch with redirect/kill,
// presenting fetched instructions to decode over a valid/ready handshake.
module pc_fetch_unit #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0,
    parameter int unsigned       INC      = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REDIRECT_VALID,
    input  logic [WIDTH-1:0] REDIRECT_PC,
    output logic             IMEM_REQ_VALID,
    input  logic             IMEM_REQ_READY,
    output logic [WIDTH-1:0] IMEM_REQ_ADDR,
    input  logic             IMEM_RSP_VALID,
    input  logic [WIDTH-1:0] IMEM_RSP_DATA,
    output logic             INSTR_VALID,
    input  logic             INSTR_READY,
    output logic [WIDTH-1:0] INSTR,
    output logic [WIDTH-1:0] INSTR_PC,
    output logic             ADDR_MISALIGNED
);

    typedef enum logic [1:0] {BOOT, ISSUE, WAIT, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] req_pc;
    logic             kill;
    logic [WIDTH-1:0] instr_q;
    logic [WIDTH-1:0] instr_pc_q;
    logic             misaligned_q;

    logic             accept;
    logic             redir;
    logic             rsp;
    logic             deliver;
    logic [WIDTH-1:0] redir_target;

    assign accept       = (state == ISSUE) && IMEM_REQ_READY;
    assign redir        = REDIRECT_VALID && (state != BOOT);
    assign rsp          = (state == WAIT) && IMEM_RSP_VALID;
    // A response is only delivered if neither an earlier nor a same-cycle redirect killed it
    assign deliver      = rsp && !kill && !redir;
    assign redir_target = {REDIRECT_PC[WIDTH-1:2], 2'b00};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            BOOT:  state_next = ISSUE;
            ISSUE: if (accept) state_next = WAIT;
            WAIT:  if (rsp) state_next = deliver ? HOLD : ISSUE;
            HOLD:  if (redir || INSTR_READY) state_next = ISSUE;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        IMEM_REQ_VALID = (state == ISSUE);
        INSTR_VALID    = (state == HOLD);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc           <= RESET_PC;
            req_pc       <= '0;
            kill         <= 1'b0;
            instr_q      <= '0;
            instr_pc_q   <= '0;
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= redir && (|REDIRECT_PC[1:0]);
            if (redir) begin
                pc <= redir_target;
            end else if (deliver) begin
                pc <= req_pc + WIDTH'(INC);
            end
            if (accept) begin
                req_pc <= pc;
            end
            // Accepting during a redirect leaves a stale request in flight
            if (accept) begin
                kill <= redir;
            end else if (rsp) begin
                kill <= 1'b0;
            end else if ((state == WAIT) && redir) begin
                kill <= 1'b1;
            end
            if (deliver) begin
                instr_q    <= IMEM_RSP_DATA;
                instr_pc_q <= req_pc;
            end
        end
    end

    assign IMEM_REQ_ADDR   = pc;
    assign INSTR           = instr_q;
    assign INSTR_PC        = instr_pc_q;
    assign ADDR_MISALIGNED = misaligned_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expected {pc, instr} pairs are queued when
// a response is driven and compared when decode sees the instruction.
module tb_pc_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req_ready = 1'b1;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        instr_ready = 1'b1;

    logic        req_valid, instr_valid, misaligned;
    logic [31:0] req_addr, instr, instr_pc;
    logic        b_req_valid, b_instr_valid, b_misaligned;
    logic [31:0] b_req_addr, b_instr, b_instr_pc;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   req_cyc = 0;
    int   c0;
    logic saw_stale = 1'b0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK)
        if (instr_valid && (instr === 32'hDEAD_BEEF || instr === 32'h1111_1111)) saw_stale <= 1'b1;

    pc_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000), .INC(4)) dut (
        .CLK(CLK), .RST(RST),
        .REDIRECT_VALID(redirect_valid), .REDIRECT_PC(redirect_pc),
        .IMEM_REQ_VALID(req_valid), .IMEM_REQ_READY(req_ready), .IMEM_REQ_ADDR(req_addr),
        .IMEM_RSP_VALID(rsp_valid), .IMEM_RSP_DATA(rsp_data),
        .INSTR_VALID(instr_valid), .INSTR_READY(instr_ready),
        .INSTR(instr), .INSTR_PC(instr_pc), .ADDR_MISALIGNED(misaligned)
    );

    pc_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0100), .INC(4)) dut_b (
        .CLK(CLK), .RST(RST),
        .REDIRECT_VALID(redirect_valid), .REDIRECT_PC(redirect_pc),
        .IMEM_REQ_VALID(b_req_valid), .IMEM_REQ_READY(req_ready), .IMEM_REQ_ADDR(b_req_addr),
        .IMEM_RSP_VALID(rsp_valid), .IMEM_RSP_DATA(rsp_data),
        .INSTR_VALID(b_instr_valid), .INSTR_READY(instr_ready),
        .INSTR(b_instr), .INSTR_PC(b_instr_pc), .ADDR_MISALIGNED(b_misaligned)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!req_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_req_valid"}, 32'(req_valid), 32'd1);
    endtask

    task automatic wait_instr(input string tag);
        int n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_instr_valid"}, 32'(instr_valid), 32'd1);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_instr"}, instr, e.instr);
            check({tag, "_instr_pc"}, instr_pc, e.pc);
        end
    endtask

    // Issue one fetch, answer it next cycle, optionally stall decode for 'hold' cycles.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                            input int hold, input string tag);
        exp_t e;
        wait_req(tag);
        check({tag, "_addr"}, req_addr, addr);
        req_cyc = cyc;
        @(negedge CLK);
        rsp_valid = 1'b1;
        rsp_data  = data;
        e.pc = addr;
        e.instr = data;
        sb.push_back(e);
        @(negedge CLK);
        rsp_valid = 1'b0;
        wait_instr(tag);
        pop_check(tag);
        if (hold > 0) begin
            instr_ready = 1'b0;
            repeat (hold) begin
                @(negedge CLK);
                check({tag, "_hold_valid"}, 32'(instr_valid), 32'd1);
                check({tag, "_hold_instr"}, instr, data);
                check({tag, "_hold_pc"}, instr_pc, addr);
                check({tag, "_hold_noreq"}, 32'(req_valid), 32'd0);
            end
            instr_ready = 1'b1;
        end
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        repeat (2) @(negedge CLK);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("t1_first_req", 32'(req_valid), 32'd1);

        // 1: sequential fetch, one instruction every 3 cycles
        do_fetch(32'h0, 32'h0000_1001, 0, "t1_a");
        c0 = req_cyc;
        do_fetch(32'h4, 32'h0000_2002, 0, "t1_b");
        check("t1_period_b", 32'(req_cyc - c0), 32'd3);
        c0 = req_cyc;
        do_fetch(32'h8, 32'h0000_3003, 0, "t1_c");
        check("t1_period_c", 32'(req_cyc - c0), 32'd3);

        // 2: reset while holding an instruction
        wait_req("t2");
        check("t2_addr", req_addr, 32'hC);
        @(negedge CLK);
        rsp_valid = 1'b1;
        rsp_data = 32'hC0C0_C0C0;
        sb.push_back({32'hC, 32'hC0C0_C0C0});
        @(negedge CLK);
        rsp_valid = 1'b0;
        instr_ready = 1'b0;
        check("t2_held", 32'(instr_valid), 32'd1);
        pop_check("t2");
        RST = 1'b1;
        #1;
        check("t2_rst_valid", 32'(instr_valid), 32'd0);
        check("t2_rst_valid_b", 32'(b_instr_valid), 32'd0);
        check("t2_rst_instr_b", b_instr, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        instr_ready = 1'b1;
        @(negedge CLK);
        check("t2_req_b", 32'(b_req_valid), 32'd1);
        check("t2_addr_b", b_req_addr, 32'h100);
        check("t2_addr_a", req_addr, 32'h0);

        // 3: redirect while waiting; late response must be dropped
        wait_req("t3");
        check("t3_addr0", req_addr, 32'h0);
        @(negedge CLK);
        redirect_valid = 1'b1;
        redirect_pc = 32'h2000;
        @(negedge CLK);
        redirect_valid = 1'b0;
        rsp_valid = 1'b1;
        rsp_data = 32'hDEAD_BEEF;
        @(negedge CLK);
        rsp_valid = 1'b0;
        check("t3_no_instr", 32'(instr_valid), 32'd0);
        check("t3_req", 32'(req_valid), 32'd1);
        check("t3_addr", req_addr, 32'h2000);
        do_fetch(32'h2000, 32'h2000_0013, 0, "t3_f");

        // 4: back-to-back redirects in ISSUE, then redirect on the accept cycle
        req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        @(negedge CLK);
        redirect_pc = 32'h8;
        @(negedge CLK);
        redirect_valid = 1'b0;
        check("t4_last_wins", req_addr, 32'h8);
        check("t4_aligned", 32'(misaligned), 32'd0);
        req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        @(negedge CLK);
        redirect_valid = 1'b0;
        rsp_valid = 1'b1;
        rsp_data = 32'h1111_1111;
        @(negedge CLK);
        rsp_valid = 1'b0;
        check("t4_no_instr", 32'(instr_valid), 32'd0);
        check("t4_addr", req_addr, 32'h40);
        do_fetch(32'h40, 32'h4040_4040, 0, "t4_f");

        // 5: decode stalls 5 cycles
        do_fetch(32'h44, 32'hA5A5_5A5A, 5, "t5");

        // Redirect while holding: instruction withdrawn
        wait_req("t7");
        check("t7_addr", req_addr, 32'h48);
        @(negedge CLK);
        rsp_valid = 1'b1;
        rsp_data = 32'h4848_4848;
        sb.push_back({32'h48, 32'h4848_4848});
        @(negedge CLK);
        rsp_valid = 1'b0;
        wait_instr("t7");
        pop_check("t7");
        instr_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        @(negedge CLK);
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        check("t7_dropped", 32'(instr_valid), 32'd0);
        check("t7_addr_redir", req_addr, 32'h300);

        // 6: misaligned redirect and wrap
        req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        @(negedge CLK);
        redirect_valid = 1'b0;
        check("t6_misaligned", 32'(misaligned), 32'd1);
        check("t6_addr", req_addr, 32'hFFFF_FFFC);
        @(negedge CLK);
        check("t6_pulse_end", 32'(misaligned), 32'd0);
        req_ready = 1'b1;
        do_fetch(32'hFFFF_FFFC, 32'hFCFC_FCFC, 0, "t6_a");
        do_fetch(32'h0, 32'h0BAD_F00D, 0, "t6_wrap");

        check("stale_never_presented", 32'(saw_stale), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
